// File: rtl/uart_tx_frame.sv
// UART transmit framer: one bit per CLK cycle, with optional even/odd parity.
// TX_OUT and Busy are registered and trail the state register by one cycle.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  par_en_reg;
    logic                  par_typ_reg;
    logic                  accept;
    logic                  tx_nxt;
    logic                  busy_nxt;

    // Even parity is the XOR of the data bits; odd parity inverts it.
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                        input logic odd);
        return (^d) ^ odd;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b1;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (Data_Valid) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                tx_nxt    = 1'b0;
                state_nxt = DATA;
            end
            DATA: begin
                tx_nxt = data_reg[bit_cnt];
                if (bit_cnt == LAST_BIT) begin
                    state_nxt = par_en_reg ? PARITY : STOP;
                end
            end
            PARITY: begin
                tx_nxt    = parity_bit(data_reg, par_typ_reg);
                state_nxt = STOP;
            end
            STOP: begin
                tx_nxt    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Frame configuration is captured once so mid-frame input changes are inert.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_reg    <= '0;
            par_en_reg  <= 1'b0;
            par_typ_reg <= 1'b0;
        end else if (accept) begin
            data_reg    <= P_DATA;
            par_en_reg  <= PAR_EN;
            par_typ_reg <= PAR_TYP;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt <= '0;
        end else if (state == START) begin
            bit_cnt <= '0;
        end else if (state == DATA) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            TX_OUT <= 1'b1;
            Busy   <= 1'b0;
        end else begin
            TX_OUT <= tx_nxt;
            Busy   <= busy_nxt;
        end
    end

endmodule

// File: doc/uart_tx_frame.md
UART_TX_FRAME -- requirements
Module: uart_tx_frame

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 8, number of data bits per frame.
REQ-002 SHALL have port: CLK  input  1  TX clock at the baud rate; one serial bit per cycle.
REQ-003 SHALL have port: RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: P_DATA  input  DATA_WIDTH  byte to transmit.
REQ-005 SHALL have port: Data_Valid  input  1  P_DATA valid request.
REQ-006 SHALL have port: PAR_EN  input  1  parity bit enable.
REQ-007 SHALL have port: PAR_TYP  input  1  parity type: 0 even, 1 odd.
REQ-008 SHALL have port: TX_OUT  output  1  serial line; idle high.
REQ-009 SHALL have port: Busy  output  1  frame in progress.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-011 SHALL accept a request only in IDLE, on a rising CLK edge with Data_Valid=1, which is cycle N.
REQ-012 SHALL ignore Data_Valid while Busy=1; no queueing, no corruption of the frame in flight.
REQ-013 SHALL latch P_DATA, PAR_EN and PAR_TYP at acceptance; input changes mid-frame have no effect.
REQ-014 SHALL register TX_OUT and Busy, with no combinational path from inputs to outputs.
REQ-015 SHALL drive the frame as follows: cycle N+1 start bit 0; cycles N+2..N+1+DATA_WIDTH data bits, LSB first.
REQ-016 SHALL, with PAR_EN=1, drive the parity bit at cycle N+2+DATA_WIDTH and the stop bit 1 at N+3+DATA_WIDTH.
REQ-017 SHALL, with PAR_EN=0, drive the stop bit 1 at cycle N+2+DATA_WIDTH, with no parity cycle.
REQ-018 SHALL compute parity bit = XOR of latched data bits for even, and the inverse of that for odd.
REQ-019 SHALL use a bit counter of width clog2(DATA_WIDTH) that clears in START and advances each DATA cycle.
REQ-020 SHALL leave DATA when the bit counter equals DATA_WIDTH-1, going to PARITY if PAR_EN latched, else to STOP.
REQ-021 SHALL assert Busy=1 from the start-bit cycle through the stop-bit cycle inclusive, and 0 otherwise.
REQ-022 SHALL return to IDLE after STOP; TX_OUT=1 and Busy=0 in IDLE.
REQ-023 SHALL accept a request held or re-asserted in IDLE right after STOP on that IDLE edge, giving exactly one idle bit between frames.
REQ-024 SHALL drive frame length of DATA_WIDTH+2 bits without parity and DATA_WIDTH+3 bits with parity, with no gaps.

Reset
REQ-025 SHALL, while RST=1, force TX_OUT=1, Busy=0, state IDLE, bit counter 0 and latched data/config 0, asynchronously.
REQ-026 SHALL abort a frame on mid-frame reset, with TX_OUT returning high immediately without waiting for a clock.
REQ-027 SHALL ignore Data_Valid while RST=1.
REQ-028 SHALL evaluate the first edge after RST deasserts as a normal IDLE edge.

Verification
REQ-029 SHALL cover: P_DATA=0xA5, PAR_EN=0 -> TX_OUT 0,1,0,1,0,0,1,0,1,1; Busy high for 10 cycles.
REQ-030 SHALL cover: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0, stop 1; Busy high for 11 cycles; then PAR_TYP=1 -> parity bit 1.
REQ-031 SHALL cover: P_DATA=0x00, PAR_EN=1, PAR_TYP=1 -> 0, eight 0s, parity 1, stop 1.
REQ-032 SHALL cover: during data bit 3 of 0x5A, pulse Data_Valid with P_DATA=0x3C and toggle PAR_EN -> frame 0x5A unchanged; 0x3C never sent.
REQ-033 SHALL cover: Data_Valid held high for 3 frames of 0xFF, PAR_EN=0 -> each frame is 10 bits, separated by exactly one idle-high cycle.
REQ-034 SHALL cover: RST pulse during data bit 5 -> TX_OUT=1 and Busy=0 before the next CLK edge; the next request sends a complete, correct frame.
